// File: rtl/pc_vector_unit_if.sv
// Vector-fetch read channel between pc_vector_unit (master) and a spare
// data-memory read port (slave). vec_data is valid in the cycle vec_ack is high.
interface pc_vector_unit_if #(
    parameter int ADDR_W = 8
);
    logic              vec_req;
    logic [ADDR_W-1:0] vec_addr;
    logic              vec_ack;
    logic [ADDR_W-1:0] vec_data;

    modport master (
        output vec_req,
        output vec_addr,
        input  vec_ack,
        input  vec_data
    );

    modport slave (
        input  vec_req,
        input  vec_addr,
        output vec_ack,
        output vec_data
    );
endinterface

// File: rtl/pc_vector_unit.sv
// Program counter that fetches its reset and interrupt vectors from data memory.
// Optional macro INTR_MASK_EN adds an intr_enable input that gates interrupt entry.
module pc_vector_unit #(
    parameter int ADDR_W         = 8,
    parameter int RESET_VEC_ADDR = 0,
    parameter int INTR_VEC_ADDR  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RESET_IN,
    input  logic              INTR_IN,
    input  logic              pc_write,
    input  logic              pc_src,
    input  logic              pc_increment,
    input  logic [ADDR_W-1:0] pc_in,
`ifdef INTR_MASK_EN
    input  logic              intr_enable,
`endif
    pc_vector_unit_if.master  vec,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] ret_pc,
    output logic              intr_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        FETCH_RST  = 2'd0,
        FETCH_INTR = 2'd1,
        RUN        = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
    logic              intr_ack_q, intr_ack_d;
    logic              intr_pending_q, intr_pending_d;
    logic              intr_en;
    logic              take;
    logic [ADDR_W-1:0] pc_step;

`ifdef INTR_MASK_EN
    assign intr_en = intr_enable;
`else
    assign intr_en = 1'b1;
`endif

    // Sequential step is +1 or +2; wraps naturally modulo 2^ADDR_W.
    assign pc_step = {{(ADDR_W-2){1'b0}}, pc_increment, ~pc_increment};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d        = state_q;
        pc_d           = pc_q;
        ret_pc_d       = ret_pc_q;
        intr_ack_d     = 1'b0;
        intr_pending_d = intr_pending_q;
        take           = 1'b0;

        unique case (state_q)
            FETCH_RST: begin
                if (vec.vec_ack) begin
                    pc_d    = vec.vec_data;
                    state_d = RUN;
                end
            end
            FETCH_INTR: begin
                // A reset request wins over a completing interrupt-vector read.
                if (RESET_IN) begin
                    state_d        = FETCH_RST;
                    intr_pending_d = 1'b0;
                end else if (vec.vec_ack) begin
                    pc_d    = vec.vec_data;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (RESET_IN) begin
                    state_d        = FETCH_RST;
                    intr_pending_d = 1'b0;
                end else if (intr_pending_q && intr_en) begin
                    take           = 1'b1;
                    ret_pc_d       = pc_q;
                    intr_ack_d     = 1'b1;
                    intr_pending_d = 1'b0;
                    state_d        = FETCH_INTR;
                end else if (pc_write) begin
                    pc_d = pc_src ? pc_in : pc_q + pc_step;
                end
            end
            default: state_d = FETCH_RST;
        endcase

        if (INTR_IN && !RESET_IN && !take && (state_q != FETCH_INTR)) begin
            intr_pending_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FETCH_RST;
            pc_q           <= '0;
            ret_pc_q       <= '0;
            intr_ack_q     <= 1'b0;
            intr_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ret_pc_q       <= ret_pc_d;
            intr_ack_q     <= intr_ack_d;
            intr_pending_q <= intr_pending_d;
        end
    end

    always_comb begin
        vec.vec_req  = 1'b0;
        vec.vec_addr = '0;
        unique case (state_q)
            FETCH_RST: begin
                vec.vec_req  = 1'b1;
                vec.vec_addr = ADDR_W'(RESET_VEC_ADDR);
            end
            FETCH_INTR: begin
                vec.vec_req  = 1'b1;
                vec.vec_addr = ADDR_W'(INTR_VEC_ADDR);
            end
            default: ;
        endcase
    end

    assign busy     = vec.vec_req;
    assign PC       = pc_q;
    assign ret_pc   = ret_pc_q;
    assign intr_ack = intr_ack_q;

endmodule

// File: tb/tb_pc_vector_unit.sv
// Scoreboard bench for pc_vector_unit: a cycle-level reference model pushes the
// expected outputs after every edge; a negedge monitor pops and compares them.
module tb_pc_vector_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, reset_in, intr_in, pc_write, pc_src, pc_inc, intr_enable;
    logic [W-1:0] pc_in, pc, ret_pc;
    logic         intr_ack, busy;

    always #5 clk = ~clk;

    pc_vector_unit_if #(.ADDR_W(W)) vif ();

    pc_vector_unit #(.ADDR_W(W), .RESET_VEC_ADDR(0), .INTR_VEC_ADDR(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .RESET_IN     (reset_in),
        .INTR_IN      (intr_in),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .pc_increment (pc_inc),
        .pc_in        (pc_in),
`ifdef INTR_MASK_EN
        .intr_enable  (intr_enable),
`endif
        .vec          (vif.master),
        .PC           (pc),
        .ret_pc       (ret_pc),
        .intr_ack     (intr_ack),
        .busy         (busy)
    );

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] ret;
        logic [W-1:0] addr;
        logic         ack;
        logic         busy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Memory contents at the two vector addresses.
    logic [W-1:0] rst_vec, intr_vec;

    // Reference model: fetching / which vector / pc / saved pc / pending / ack pulse.
    bit           m_fetch, m_fi, m_pend, m_ack;
    logic [W-1:0] m_pc, m_ret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit take, was_fi, en, pend_n;
        if (rst) begin
            m_fetch = 1; m_fi = 0; m_pc = '0; m_ret = '0; m_pend = 0; m_ack = 0;
        end else begin
            take   = 0;
            was_fi = m_fetch && m_fi;
`ifdef INTR_MASK_EN
            en = intr_enable;
`else
            en = 1;
`endif
            pend_n = m_pend;
            if (m_fetch) begin
                if (m_fi && reset_in) begin
                    m_fi = 0; pend_n = 0;
                end else if (vif.vec_ack) begin
                    m_pc = vif.vec_data; m_fetch = 0; m_fi = 0;
                end
            end else if (reset_in) begin
                m_fetch = 1; m_fi = 0; pend_n = 0;
            end else if (m_pend && en) begin
                take = 1; m_ret = m_pc; m_fetch = 1; m_fi = 1; pend_n = 0;
            end else if (pc_write) begin
                m_pc = pc_src ? pc_in : W'(int'(m_pc) + (pc_inc ? 2 : 1));
            end
            if (intr_in && !reset_in && !take && !was_fi) pend_n = 1;
            m_pend = pend_n;
            m_ack  = take;
        end
        sb.push_back('{pc: m_pc, ret: m_ret, addr: (m_fetch && m_fi) ? W'(1) : W'(0),
                       ack: m_ack, busy: m_fetch});
    endtask

    // One clock of stimulus; inputs change just after the falling edge.
    task automatic cyc(input bit r, input bit ri, input bit ii, input bit pw, input bit ps,
                       input bit pi, input logic [W-1:0] pin, input bit ack);
        rst = r; reset_in = ri; intr_in = ii; pc_write = pw; pc_src = ps; pc_inc = pi;
        pc_in = pin;
        vif.vec_ack  = ack;
        vif.vec_data = m_fetch ? (m_fi ? intr_vec : rst_vec) : W'($urandom);
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc",       pc,           e.pc);
            check("ret_pc",   ret_pc,       e.ret);
            check("intr_ack", intr_ack,     e.ack);
            check("busy",     busy,         e.busy);
            check("vec_req",  vif.vec_req,  e.busy);
            check("vec_addr", vif.vec_addr, e.addr);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; reset_in = 0; intr_in = 0; pc_write = 0; pc_src = 0; pc_inc = 0;
        pc_in = '0; intr_enable = 1; vif.vec_ack = 0; vif.vec_data = '0;
        rst_vec = 8'h00; intr_vec = 8'h50;
        m_fetch = 1; m_fi = 0; m_pc = '0; m_ret = '0; m_pend = 0; m_ack = 0;

        // Reset vector fetch with two wait cycles.
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 8'h00, 0);
        repeat (2) cyc(0, 0, 0, 1, 1, 0, 8'h77, 0);
        cyc(0, 0, 0, 1, 1, 0, 8'h77, 1);

        // Sequencing, jumps, stalls and wrap-around.
        cyc(0, 0, 0, 1, 1, 0, 8'h02, 0);
        repeat (2) cyc(0, 0, 0, 1, 0, 1, 8'h00, 0);
        cyc(0, 0, 0, 1, 1, 0, 8'h20, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0, 8'h99, 0);
        cyc(0, 0, 0, 1, 1, 0, 8'hFF, 0);
        cyc(0, 0, 0, 1, 0, 1, 8'h00, 0);
        cyc(0, 0, 0, 1, 1, 0, 8'hFF, 0);
        cyc(0, 0, 0, 1, 0, 0, 8'h00, 0);

        // Interrupt entry from PC=0x12 with one wait cycle on the vector read.
        cyc(0, 0, 0, 1, 1, 0, 8'h12, 0);
        cyc(0, 0, 1, 0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 1, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0);

        // Interrupt raised during the reset-vector fetch.
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 1);

        // RESET_IN aborts an interrupt fetch even with vec_ack high.
        cyc(0, 0, 0, 1, 1, 0, 8'h40, 0);
        cyc(0, 0, 1, 0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0);
        cyc(0, 1, 0, 0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 8'h00, 0);

        // Asynchronous rst in the middle of an interrupt fetch.
        cyc(0, 0, 1, 0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 1);

`ifdef INTR_MASK_EN
        // Masked interrupt stays pending while the PC keeps counting.
        intr_enable = 0;
        cyc(0, 0, 0, 1, 1, 0, 8'h30, 0);
        cyc(0, 0, 1, 1, 0, 0, 8'h00, 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 0, 8'h00, 0);
        intr_enable = 1;
        repeat (2) cyc(0, 0, 0, 1, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 0, 0, 0, 8'h00, 1);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst_vec  = W'($urandom);
                intr_vec = W'($urandom);
            end
`ifdef INTR_MASK_EN
            if ($urandom_range(0, 9) == 0) intr_enable = ~intr_enable;
`endif
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 3, 1'($urandom), W'($urandom),
                $urandom_range(0, 9) < 4);
        end

        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_vector_unit.md
Name: pc_vector_unit

Overview:
Parametrised successor to the 8-bit program counter. It adds vector fetch from data memory: the reset and interrupt vectors are read from memory over a req/ack handshake instead of arriving on static vector inputs. It also adds a sticky interrupt-pending latch, a saved return PC, and a configurable address width. It sits between the control unit, the instruction-memory address port, and a spare read port of data memory.

Parameters:
ADDR_W, 8, width of PC, pc_in, vec_addr, vec_data, ret_pc
RESET_VEC_ADDR, 0, data-memory address holding the reset vector
INTR_VEC_ADDR, 1, data-memory address holding the interrupt vector

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
RESET_IN  in  1  external synchronous reset request, sampled on clk
INTR_IN  in  1  interrupt request, level, sampled on clk
pc_write  in  1  PC update enable in RUN (0 = stall/hold)
pc_src  in  1  1 = load pc_in, 0 = sequential
pc_increment  in  1  0 = +1, 1 = +2 (two-byte instruction)
pc_in  in  ADDR_W  branch/jump target
vec_req  out  1  vector read request to data memory
vec_addr  out  ADDR_W  vector address (valid while vec_req)
vec_ack  in  1  memory accepted request; vec_data valid same cycle
vec_data  in  ADDR_W  vector value returned
PC  out  ADDR_W  current program counter
ret_pc  out  ADDR_W  PC saved on interrupt entry
intr_ack  out  1  one-cycle pulse when interrupt is taken
busy  out  1  high while a vector fetch is in progress

Behaviour:
- States: FETCH_RST, FETCH_INTR, RUN. State and all outputs are registered or decoded from the state register.
- rst=1 (async): state=FETCH_RST, PC=0, ret_pc=0, intr_ack=0, intr_pending=0.
- Decoded outputs:
  - vec_req=1 in FETCH_RST or FETCH_INTR.
  - vec_addr=RESET_VEC_ADDR in FETCH_RST, INTR_VEC_ADDR in FETCH_INTR, 0 in RUN.
  - busy=vec_req.
- FETCH_x: hold vec_req and vec_addr stable until vec_ack. On the edge with vec_req&vec_ack: PC<=vec_data, state<=RUN. pc_write, pc_src and pc_in are ignored. Unbounded wait is legal.
- RUN priority, highest first:
  1. RESET_IN=1: state<=FETCH_RST, intr_pending<=0, PC unchanged until the fetch completes.
  2. intr_pending=1: ret_pc<=PC, intr_ack<=1 for exactly one cycle, intr_pending<=0, state<=FETCH_INTR. PC holds.
  3. pc_write=1 & pc_src=1: PC<=pc_in.
  4. pc_write=1 & pc_src=0: PC<=PC+1 or PC+2, modulo 2^ADDR_W (0xFF+1=0x00, 0xFF+2=0x01 at ADDR_W=8).
  5. pc_write=0: PC holds.
- RESET_IN in FETCH_INTR: abort to FETCH_RST next edge, even if vec_ack is high that edge; clear pending. RESET_IN in FETCH_RST: stay, no effect.
- intr_pending:
  - Set on any edge with INTR_IN=1, except in FETCH_INTR, on the take edge, or when RESET_IN=1.
  - Sticky. An interrupt raised during FETCH_RST is taken on the first RUN cycle after the fetch.
- Latency:
  - INTR_IN high at edge N: pending at N, taken at N+1 (intr_ack high after N+1).
  - vec_req high in the cycle after N+1; PC=vector one edge after vec_ack.
- rst asserted mid-fetch: immediate return to FETCH_RST; vec_req stays high with vec_addr=RESET_VEC_ADDR.

Optional Feature:
INTR_MASK_EN
- Defined: adds input intr_enable (1 bit). Pending is set regardless of intr_enable, but is taken only when intr_enable=1; otherwise the PC continues normally and the request stays pending.
- Undefined: no intr_enable port; pending interrupts are always taken.

Test Plan:
- Reset vector: rst pulse, M[0]=0x00, vec_ack after 2 wait cycles -> busy=1 and vec_addr=0x00 throughout, then PC=0x00 in RUN.
- Sequencing: PC=0x02, pc_write=1, pc_increment=1 for 2 edges -> 0x04, 0x06. pc_src=1, pc_in=0x20 -> 0x20. pc_write=0 for 2 edges -> holds 0x20. PC=0xFF, +2 -> 0x01.
- Interrupt: PC=0x12, INTR_IN one-cycle pulse, M[1]=0x50 -> intr_ack single pulse, ret_pc=0x12, vec_addr=0x01, PC=0x50 after ack.
- Interrupt during reset fetch: INTR_IN pulse while FETCH_RST -> after reset vector loads, next cycle intr_ack=1, then fetch from addr 0x01.
- RESET_IN during FETCH_INTR with vec_ack high -> state FETCH_RST, vec_addr=0x00, PC not loaded with 0x50, no pending interrupt afterwards.
- INTR_MASK_EN: intr_enable=0, INTR_IN pulse -> PC increments 0x30, 0x31, ...; raise intr_enable -> intr_ack next cycle, ret_pc equals PC at that edge.
